mc_ctrl: RTL
============

# mc_ctrl

Multicycle sequencing controller for the RV32I core datapath (PC, instruction register, regfile, immgen, brcomp, ALU, LSU, writeback mux). It replaces the purely combinational single-cycle control with a Moore FSM. Each instruction is split into FETCH/DECODE/EXEC/MEM/WB steps, so instruction and data memory can share one handshaked port with wait states. It also keeps a retired-instruction counter and a sticky illegal-instruction flag.

## Interface
- No parameters; encodings come from `mc_pkg`.
- `clk_i` in 1: clock; all state on its rising edge.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `instr_i` in 32: instruction register contents (stable from DECODE to end of instruction).
- `br_less_i`, `br_equal_i` in 1 each: brcomp results.
- `mem_ack_i` in 1: memory port completion, sampled while `mem_req_o`=1.
- `mem_req_o` out 1: memory request. Held until ack.
- `mem_we_o` out 1: 1 = store, 0 = read (fetch or load).
- `mem_addr_sel_o` out 1: 0 = PC (fetch), 1 = ALU result (load/store).
- `ir_wren_o` out 1: latch fetched word into the IR.
- `pc_wren_o` out 1: update the PC.
- `br_sel_o` out 1: next PC source, 0 = PC+4, 1 = ALU.
- `rd_wren_o` out 1: regfile write enable.
- `op_a_sel_o`, `op_b_sel_o` out 1 each: 0 = rs1/rs2, 1 = PC/imm.
- `br_unsigned_o` out 1: unsigned compare.
- `alu_op_o` out 4: ALU operation.
- `wb_sel_o` out 2: writeback source, 0 = ALU, 1 = load, 2 = PC+4.
- `state_o` out 3: current state.
- `instr_done_o` out 1: one-cycle pulse on the last cycle of each instruction.
- `minstret_o` out 32: retired-instruction count.
- `illegal_o` out 1: sticky illegal-opcode flag.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - Assert `mem_req_o`, `mem_we_o`=0, `mem_addr_sel_o`=0.
  - On `mem_ack_i`, assert `ir_wren_o` in that cycle and go to DECODE.
  - Without ack, stay in FETCH.
- DECODE:
  - Single cycle.
  - Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. These go to EXEC.
  - Any other opcode goes to HALT and sets `illegal_o`.
- EXEC: drives `op_a_sel_o`, `op_b_sel_o` and `alu_op_o` per opcode.
  - R/I-type ALU: → WB.
  - Load/store: `alu_op_o` = ADD with rs1+imm; → MEM.
  - Branch:
    - rs1/rs2 go to brcomp; `br_unsigned_o` = funct3[1].
    - The ALU computes PC+imm.
    - Taken is: beq equal; bne !equal; blt/bltu less; bge/bgeu !less.
    - `pc_wren_o`=1 with `br_sel_o` = taken.
    - Retire; → FETCH.
  - JAL (PC+imm) and JALR (rs1+imm): → WB.
  - LUI: `alu_op_o` = PASSB.
  - AUIPC: PC+imm.
  - LUI and AUIPC → WB.
- MEM: hold the EXEC ALU controls. Assert `mem_req_o`, `mem_addr_sel_o`=1, and `mem_we_o` = store.
  - Without ack: stay.
  - On ack, load: → WB.
  - On ack, store: `pc_wren_o`=1, `br_sel_o`=0, retire, → FETCH.
- WB: `rd_wren_o`=1 and `pc_wren_o`=1, then retire and → FETCH.
  - `wb_sel_o`: 1 for load, 2 for JAL/JALR, else 0.
  - `br_sel_o`=1 only for JAL/JALR.
  - For JAL/JALR the ALU is held on the target.
- HALT: absorbing state. All enables are 0 and no request is made; only reset leaves it.
- ALU decode:
  - R-type uses {funct7[5], funct3}.
  - I-type uses funct3, and funct7[5] only when funct3=101 (SRAI).
- Retire means `instr_done_o`=1 and `minstret_o` += 1. `minstret_o` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: state=FETCH, `minstret_o`=0, `illegal_o`=0. All other outputs are 0 except the FETCH Moore outputs, so `mem_req_o`=1 from the first cycle after release.
- Reset mid-instruction: abort at once with no PC or regfile write. A pending request is dropped.
- Outputs are Moore (decoded from state plus IR), except `ir_wren_o`, `pc_wren_o` and `instr_done_o` in FETCH/MEM, which are gated by `mem_ack_i`.
- Zero-wait latency, in cycles:
  - ALU/LUI/AUIPC/JAL/JALR: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
- Each wait cycle adds 1.
- `mem_ack_i` while `mem_req_o`=0 is ignored.
- Exactly one retire occurs per instruction. `pc_wren_o` is asserted exactly once per instruction, always in the retire cycle.

## Structure
- `mc_pkg` holds:
  - State enum.
  - Opcode constants.
  - `alu_op` encodings: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
  - `wb_sel` encodings.
- One sub-module, `mc_alu_dec`: combinational mapping of {opcode, funct3, funct7[5]} to `alu_op`.

## Test plan
- addi x1,x0,5 with ack in the request cycle → states 0,1,2,4; `rd_wren_o` and `pc_wren_o` high in cycle 4; `minstret_o`=1.
- lw with fetch ack delayed 2 cycles and MEM ack delayed 3 cycles → 10 cycles total, `wb_sel_o`=1 in WB, `mem_addr_sel_o`=1 only in MEM.
- beq with `br_equal_i`=1 → EXEC has `pc_wren_o`=1, `br_sel_o`=1, `rd_wren_o`=0. With `br_equal_i`=0 → `br_sel_o`=0.
- sw with zero-wait → 4 cycles, `mem_we_o`=1 only in MEM, no `rd_wren_o`.
- Opcode 0000000 → HALT, `illegal_o`=1. With 20 further acks: `mem_req_o` stays 0 and `minstret_o` is unchanged.
- `rst_ni` pulsed low during a stalled MEM → next cycle state=FETCH, `minstret_o`=0, with no `pc_wren_o`/`rd_wren_o` pulse; preset `minstret_o` to 0xFFFFFFFF and retire once → 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencing controller.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_R)      || (op == OP_I)     || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR)   || (op == OP_LUI)   || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode from opcode, funct3 and funct7[5].
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_op_e    alu_op_o
);

  // Only R/I-type use the funct fields; everything else adds or passes B.
  always_comb begin
    alu_op_o = ALU_ADD;
    if (opcode_i == OP_LUI) begin
      alu_op_o = ALU_PASSB;
    end else if (opcode_i == OP_R || opcode_i == OP_I) begin
      unique case (funct3_i)
        3'b000: alu_op_o = (opcode_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
        3'b001: alu_op_o = ALU_SLL;
        3'b010: alu_op_o = ALU_SLT;
        3'b011: alu_op_o = ALU_SLTU;
        3'b100: alu_op_o = ALU_XOR;
        3'b101: alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
        3'b110: alu_op_o = ALU_OR;
        default: alu_op_o = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle Moore sequencing controller for the RV32I datapath.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_wren_o,
  output logic        pc_wren_o,
  output logic        br_sel_o,
  output logic        rd_wren_o,
  output logic        op_a_sel_o,
  output logic        op_b_sel_o,
  output logic        br_unsigned_o,
  output logic [3:0]  alu_op_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  state_o,
  output logic        instr_done_o,
  output logic [31:0] minstret_o,
  output logic        illegal_o
);

  state_e      state_q;
  logic [31:0] minstret_q;
  logic        illegal_q;
  alu_op_e     dec_op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_load, is_store, is_branch, is_jump, is_jal, is_auipc;
  logic       taken;
  logic       unused_instr_bits;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jump   = is_jal || (opcode == OP_JALR);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  mc_alu_dec u_alu_dec (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7b5_i (instr_i[30]),
    .alu_op_o   (dec_op)
  );

  // Branch condition from brcomp flags and funct3.
  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:          taken = br_equal_i;
      3'b001:          taken = !br_equal_i;
      3'b100, 3'b110:  taken = br_less_i;
      3'b101, 3'b111:  taken = !br_less_i;
      default:         taken = 1'b0;
    endcase
  end

  // Moore output decode; only the FETCH/MEM strobes are gated by the ack.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_wren_o      = 1'b0;
    pc_wren_o      = 1'b0;
    br_sel_o       = 1'b0;
    rd_wren_o      = 1'b0;
    op_a_sel_o     = 1'b0;
    op_b_sel_o     = 1'b0;
    br_unsigned_o  = 1'b0;
    alu_op_o       = ALU_ADD;
    wb_sel_o       = WB_ALU;
    instr_done_o   = 1'b0;
    // ALU controls are held from EXEC through WB so the result stays valid.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      op_a_sel_o = is_branch || is_jal || is_auipc;
      op_b_sel_o = !is_r;
      alu_op_o   = dec_op;
    end
    unique case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        ir_wren_o = mem_ack_i;
      end
      S_EXEC: begin
        if (is_branch) begin
          br_unsigned_o = funct3[1];
          pc_wren_o     = 1'b1;
          br_sel_o      = taken;
          instr_done_o  = 1'b1;
        end
      end
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = is_store;
        if (mem_ack_i && is_store) begin
          pc_wren_o    = 1'b1;
          instr_done_o = 1'b1;
        end
      end
      S_WB: begin
        rd_wren_o    = 1'b1;
        pc_wren_o    = 1'b1;
        instr_done_o = 1'b1;
        br_sel_o     = is_jump;
        wb_sel_o     = is_load ? WB_LOAD : (is_jump ? WB_PC4 : WB_ALU);
      end
      default: ;
    endcase
  end

  // State sequencing, retire counter and sticky illegal flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_FETCH;
      minstret_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      if (instr_done_o) minstret_q <= minstret_q + 32'd1;
      unique case (state_q)
        S_FETCH:  if (mem_ack_i) state_q <= S_DECODE;
        S_DECODE: begin
          if (is_legal_op(opcode)) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_branch)                 state_q <= S_FETCH;
          else if (is_load || is_store)  state_q <= S_MEM;
          else                           state_q <= S_WB;
        end
        S_MEM:    if (mem_ack_i) state_q <= is_store ? S_FETCH : S_WB;
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= S_HALT;
      endcase
    end
  end

  assign state_o    = state_q;
  assign minstret_o = minstret_q;
  assign illegal_o  = illegal_q;

endmodule
